// File: rtl/pixel_pkg.sv
// Shared pixel types and chroma-key rule for the ARGB writer path and the compositor.
// The phase enum names the byte lane the next accepted channel byte fills.
package pixel_pkg;

    localparam int IMG_W      = 30;
    localparam int IMG_H      = 25;
    localparam int NUM_PIXELS = IMG_W * IMG_H;
    localparam int KEY_G_MIN  = 200;
    localparam int KEY_RB_MAX = 200;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } argb_t;

    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_R = 2'd1,
        PH_G = 2'd2,
        PH_B = 2'd3
    } phase_t;

    // Green-screen test: strong green with red and blue both below threshold.
    function automatic logic is_key(argb_t p);
        return (p.g >= 8'(KEY_G_MIN)) && (p.r < 8'(KEY_RB_MAX)) && (p.b < 8'(KEY_RB_MAX));
    endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// Single-entry valid/ready output slot holding one tagged pixel word.
// A load always wins over a drain, so a same-cycle transfer and completion keeps valid high.
module pixel_out_reg
    import pixel_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  argb_t            load_pixel,
    input  logic [IDX_W-1:0] load_index,
    input  logic             load_key,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_pixel,
    output logic [IDX_W-1:0] out_index,
    output logic             out_key,
    output logic             out_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_index <= '0;
            out_key   <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pixel <= load_pixel;
            out_index <= load_index;
            out_key   <= load_key;
            out_last  <= load_last;
        end else if (out_ready) begin
            // Payload is left in place; only valid drops after a transfer.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/argb_pixel_packer.sv
// Byte-serial A,R,G,B channel stream to 32-bit #aarrggbb words tagged with frame index,
// chroma-key flag and end-of-frame; in_sof resynchronises the byte phase and pixel count.
//
// Handshake: a beat moves on either side only in a cycle where valid && ready are both high;
// the producer holds its payload steady while valid && !ready, and ready never waits on valid.
module argb_pixel_packer
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS = pixel_pkg::NUM_PIXELS,
    parameter int IDX_W      = $clog2(NUM_PIXELS),
    parameter int KEY_G_MIN  = pixel_pkg::KEY_G_MIN,
    parameter int KEY_RB_MAX = pixel_pkg::KEY_RB_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pixel,
    output logic [IDX_W-1:0] out_index,
    output logic             out_key,
    output logic             out_last,
    output logic             sync_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    localparam logic [7:0]       G_MIN    = 8'(KEY_G_MIN);
    localparam logic [7:0]       RB_MAX   = 8'(KEY_RB_MAX);

    phase_t           ph_q, ph_d;
    logic [IDX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]       a_q, r_q, g_q;
    logic             sync_err_q;
    logic             accept;
    logic             complete;
    logic             new_key;
    argb_t            new_pixel;

    // Only the blue byte can stall, and only when the slot is full and not draining.
    assign in_ready  = (ph_q != PH_B) || !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && !in_sof && (ph_q == PH_B);
    assign new_pixel = '{a: a_q, r: r_q, g: g_q, b: in_data};
    assign new_key   = (g_q >= G_MIN) && (r_q < RB_MAX) && (in_data < RB_MAX);
    assign sync_err  = sync_err_q;

    always_comb begin
        ph_d      = ph_q;
        pix_cnt_d = pix_cnt_q;
        if (accept) begin
            if (in_sof) begin
                // The sof byte is always the alpha of pixel 0.
                ph_d      = PH_R;
                pix_cnt_d = '0;
            end else begin
                unique case (ph_q)
                    PH_A: ph_d = PH_R;
                    PH_R: ph_d = PH_G;
                    PH_G: ph_d = PH_B;
                    PH_B: begin
                        ph_d      = PH_A;
                        pix_cnt_d = (pix_cnt_q == LAST_IDX) ? '0 : pix_cnt_q + 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q       <= PH_A;
            pix_cnt_q  <= '0;
            a_q        <= '0;
            r_q        <= '0;
            g_q        <= '0;
            sync_err_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            pix_cnt_q  <= pix_cnt_d;
            sync_err_q <= accept && in_sof && ((ph_q != PH_A) || (pix_cnt_q != '0));
            if (accept) begin
                if (in_sof || ph_q == PH_A) begin
                    a_q <= in_data;
                end else if (ph_q == PH_R) begin
                    r_q <= in_data;
                end else if (ph_q == PH_G) begin
                    g_q <= in_data;
                end
            end
        end
    end

    pixel_out_reg #(
        .IDX_W(IDX_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_pixel(new_pixel),
        .load_index(pix_cnt_q),
        .load_key  (new_key),
        .load_last (pix_cnt_q == LAST_IDX),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_index (out_index),
        .out_key   (out_key),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_argb_pixel_packer.sv
// Bench for argb_pixel_packer: directed steps plus random bytes, checked against a
// byte-list model of the A,R,G,B grouping, frame counting, keying and resync rules.
module tb_argb_pixel_packer;

  localparam int NPIX = 750;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pixel;
  logic [9:0]  out_index;
  logic        out_key;
  logic        out_last;
  logic        sync_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int exp_err = 0;
  bit rand_mode = 0;

  // Scoreboard words: {pixel[31:0], index[9:0], key, last}
  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];
  logic [7:0]  part[$];
  int          m_cnt = 0;

  argb_pixel_packer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_index(out_index),
    .out_key  (out_key),
    .out_last (out_last),
    .sync_err (sync_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // monitor: transfers and sync_err pulse cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_pixel, out_index, out_key, out_last});
    if (sync_err) err_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: group bytes into pixels by counting, not by phase encoding
  function automatic void model_byte(input logic [7:0] d, input logic sof);
    logic key;
    if (sof) begin
      if (part.size() != 0 || m_cnt != 0) exp_err++;
      part.delete();
      part.push_back(d);
      m_cnt = 0;
    end else begin
      part.push_back(d);
      if (part.size() == 4) begin
        key = (part[2] >= 8'd200) && (part[1] < 8'd200) && (part[3] < 8'd200);
        exp_q.push_back({part[0], part[1], part[2], part[3], 10'(m_cnt), key, (m_cnt == NPIX - 1)});
        m_cnt = (m_cnt + 1) % NPIX;
        part.delete();
      end
    end
  endfunction

  function automatic void model_reset();
    part.delete();
    m_cnt = 0;
    exp_q.delete();
  endfunction

  // driver: present one byte until accepted (bounded)
  task automatic send(input logic [7:0] d, input logic sof);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!acc && n < 200) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (acc) model_byte(d, sof);
    else chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_pixel(input logic [31:0] p, input logic sof);
    send(p[31:24], sof);
    send(p[23:16], 1'b0);
    send(p[15:8], 1'b0);
    send(p[7:0], 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_sb(input string tag);
    int n;
    drain();
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_sync_err"}, 64'(err_seen), 64'(exp_err));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_pixel"}, 64'(out_pixel), 64'd0);
    chk({tag, "_index"}, 64'(out_index), 64'd0);
    chk({tag, "_key"}, 64'(out_key), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_sync_err"}, 64'(sync_err), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] p1;
    logic [31:0] p2;
    logic [7:0]  sof_byte;
    int          t0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // first pixel with frame start, one cycle latency
    out_ready = 1'b1;
    send_pixel(32'hFF10E020, 1'b1);
    chk("p0_valid", 64'(out_valid), 64'd1);
    chk("p0_pixel", 64'(out_pixel), 64'hFF10E020);
    chk("p0_index", 64'(out_index), 64'd0);
    chk("p0_key", 64'(out_key), 64'd1);
    chk("p0_last", 64'(out_last), 64'd0);

    // key thresholds
    send_pixel(32'h80C8FF00, 1'b0);
    chk("key_r200", 64'(out_key), 64'd0);
    send_pixel(32'h4000C700, 1'b0);
    chk("key_g199", 64'(out_key), 64'd0);
    send_pixel(32'h40C7C8C7, 1'b0);
    chk("key_g200_rb199", 64'(out_key), 64'd1);
    chk("key_index", 64'(out_index), 64'd3);
    check_sb("directed");

    // backpressure: blue byte of second pixel stalls behind a full slot
    p1 = $urandom;
    p2 = $urandom;
    out_ready = 1'b0;
    send_pixel(p1, 1'b0);
    send(p2[31:24], 1'b0);
    send(p2[23:16], 1'b0);
    send(p2[15:8], 1'b0);
    in_valid = 1'b1;
    in_data  = p2[7:0];
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold", 64'(out_pixel), 64'(p1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(p2[7:0], 1'b0);
    check_sb("stall");

    // full frame plus one, frame start mid-count (short-frame resync), 4 cycles/pixel
    t0 = cyc;
    send_pixel($urandom, 1'b1);
    for (int i = 1; i <= NPIX; i++) send_pixel($urandom, 1'b0);
    chk("throughput_cycles", 64'(cyc - t0), 64'(4 * (NPIX + 1)));
    drain();
    chk("frame_last_749", 64'(got_q[NPIX - 1][0]), 64'd1);
    chk("frame_wrap_index", 64'(got_q[NPIX][11:2]), 64'd0);
    chk("frame_wrap_last", 64'(got_q[NPIX][0]), 64'd0);
    check_sb("frame");

    // clean restart, then sof on the 2nd byte of pixel 5
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    send_pixel($urandom, 1'b1);
    chk("sof_clean_no_err", 64'(sync_err), 64'd0);
    for (int i = 1; i < 5; i++) send_pixel($urandom, 1'b0);
    send(8'($urandom), 1'b0);
    sof_byte = 8'($urandom);
    send(sof_byte, 1'b1);
    @(negedge clk);
    chk("resync_pulse", 64'(sync_err), 64'd1);
    @(negedge clk);
    chk("resync_pulse_end", 64'(sync_err), 64'd0);
    @(posedge clk);
    #1;
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    drain();
    chk("resync_emitted", 64'(got_q.size()), 64'd6);
    chk("resync_index", 64'(got_q[got_q.size() - 1][11:2]), 64'd0);
    chk("resync_alpha", 64'(got_q[got_q.size() - 1][43:36]), 64'(sof_byte));
    check_sb("resync");

    // reset mid-pixel with a pending word
    out_ready = 1'b0;
    send_pixel($urandom, 1'b0);
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    chk("midreset_no_xfer", 64'(got_q.size()), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_pixel(32'h11223344, 1'b0);
    chk("midreset_index", 64'(out_index), 64'd0);
    check_sb("midreset");

    // random bytes, random backpressure, occasional resync
    rand_mode = 1;
    for (int i = 0; i < 60; i++) begin
      for (int b = 0; b < 4; b++) send(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
    end
    rand_mode = 0;
    check_sb("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
